// File: rtl/lfsr_prbs_checker.sv
// PRBS checker for a parallel Fibonacci LFSR stream.
// The checker starts in HUNT and looks for consecutive correct transitions.
// After enough good transitions it moves to LOCKED. In LOCKED it compares each
// sample against a free-running reference copy of the sequence, and counts the
// mismatches in a saturating counter.
module lfsr_prbs_checker #(
   parameter int unsigned      WIDTH      = 4,
   parameter logic [WIDTH-1:0] TAPS       = 4'b1100,
   parameter int unsigned      LOCK_CNT   = 4,
   parameter int unsigned      MISS_LIMIT = 3,
   parameter int unsigned      CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             clear_i,
   output logic             locked_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic             stuck_o
);

   localparam int unsigned MC_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned MS_W = $clog2(MISS_LIMIT + 1);
   localparam logic [MC_W-1:0]  MC_ONE  = MC_W'(1);
   localparam logic [MC_W-1:0]  LOCK_V  = MC_W'(LOCK_CNT);
   localparam logic [MS_W-1:0]  MS_ONE  = MS_W'(1);
   localparam logic [MS_W-1:0]  MISS_V  = MS_W'(MISS_LIMIT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic             prev_vld_q, prev_vld_d;
   logic [MC_W-1:0]  match_q, match_d;
   logic [MS_W-1:0]  miss_q, miss_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             stuck_q, stuck_d;
   logic             good;
   logic             count_err;

   function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], ^(s & TAPS)};
   endfunction

   // Next-state logic: hunt/lock FSM, reference tracking and the error counter.
   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      exp_d      = exp_q;
      prev_vld_d = prev_vld_q;
      match_d    = match_q;
      miss_d     = miss_q;
      cnt_d      = cnt_q;
      err_d      = 1'b0;
      stuck_d    = stuck_q;
      good       = 1'b0;
      count_err  = 1'b0;

      if (valid_i) begin
         stuck_d = (data_i == '0);
         case (state_q)
            HUNT: begin
               // An all-zero sample is never good, so the checker cannot lock onto the lockup state.
               good       = prev_vld_q && (data_i != '0) && (data_i == lfsr_next(prev_q));
               prev_d     = data_i;
               prev_vld_d = 1'b1;
               if (good) begin
                  if (match_q + MC_ONE == LOCK_V) begin
                     state_d = LOCKED;
                     exp_d   = lfsr_next(data_i);
                     miss_d  = '0;
                     match_d = '0;
                  end else begin
                     match_d = match_q + MC_ONE;
                  end
               end else begin
                  match_d = '0;
               end
            end
            LOCKED: begin
               // The reference advances freely and is never reseeded from data_i.
               exp_d = lfsr_next(exp_q);
               if (data_i == exp_q) begin
                  miss_d = '0;
               end else begin
                  err_d     = 1'b1;
                  count_err = 1'b1;
                  if (miss_q + MS_ONE == MISS_V) begin
                     state_d    = HUNT;
                     match_d    = '0;
                     miss_d     = '0;
                     prev_d     = data_i;
                     prev_vld_d = 1'b1;
                  end else begin
                     miss_d = miss_q + MS_ONE;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end

      // When clear_i and a counted mismatch occur in the same cycle, the mismatch survives the clear.
      if (clear_i) begin
         cnt_d = count_err ? CNT_ONE : '0;
      end else if (count_err && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= HUNT;
         prev_q     <= '0;
         exp_q      <= '0;
         prev_vld_q <= 1'b0;
         match_q    <= '0;
         miss_q     <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         stuck_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         exp_q      <= exp_d;
         prev_vld_q <= prev_vld_d;
         match_q    <= match_d;
         miss_q     <= miss_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         stuck_q    <= stuck_d;
      end
   end

   assign locked_o  = (state_q == LOCKED);
   assign err_o     = err_q;
   assign err_cnt_o = cnt_q;
   assign stuck_o   = stuck_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Scoreboard bench for lfsr_prbs_checker.
// The driver pushes hand-computed expected outputs for each clock edge.
// The monitor pops one entry after each edge and compares it with the DUT outputs.
// Instance a uses the default parameters. Instance b uses CNT_W=2.
module tb_lfsr_prbs_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, vld_a, clr_a;
   logic [3:0] dat_a;
   logic       lk_a, er_a, st_a;
   logic [15:0] cnt_a;

   logic       rst_b, vld_b, clr_b;
   logic [3:0] dat_b;
   logic       lk_b, er_b, st_b;
   logic [1:0] cnt_b;

   lfsr_prbs_checker u_dut_a (
      .clk(clk), .reset(rst_a), .valid_i(vld_a), .data_i(dat_a), .clear_i(clr_a),
      .locked_o(lk_a), .err_o(er_a), .err_cnt_o(cnt_a), .stuck_o(st_a)
   );

   lfsr_prbs_checker #(.CNT_W(2)) u_dut_b (
      .clk(clk), .reset(rst_b), .valid_i(vld_b), .data_i(dat_b), .clear_i(clr_b),
      .locked_o(lk_b), .err_o(er_b), .err_cnt_o(cnt_b), .stuck_o(st_b)
   );

   typedef struct {
      bit          sel;
      logic [18:0] expv;   // {locked, err, stuck, cnt[15:0]}
      string       name;
   } exp_t;

   exp_t q[$];
   int   tests_run = 0;
   int   tests_failed = 0;

   // One output check per clock edge, against the entry queued for that edge.
   initial begin
      exp_t        e;
      logic [18:0] act;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            act = e.sel ? {lk_b, er_b, st_b, 14'd0, cnt_b} : {lk_a, er_a, st_a, cnt_a};
            tests_run++;
            if (act !== e.expv) begin
               tests_failed++;
               $display("FAIL %s: got lk=%b err=%b stuck=%b cnt=%0d, required lk=%b err=%b stuck=%b cnt=%0d",
                        e.name, act[18], act[17], act[16], act[15:0],
                        e.expv[18], e.expv[17], e.expv[16], e.expv[15:0]);
            end
         end
      end
   end

   // Drives one cycle on the chosen DUT and queues the outputs expected after the next edge.
   task automatic step(input bit sel, input logic rst, input logic v, input logic [3:0] d,
                       input logic clr, input logic lk, input logic er, input int cnt,
                       input logic st, input string name);
      exp_t e;
      if (sel) begin
         rst_b = rst; vld_b = v; dat_b = d; clr_b = clr;
         rst_a = 1'b1; vld_a = 1'b0; clr_a = 1'b0;
      end else begin
         rst_a = rst; vld_a = v; dat_a = d; clr_a = clr;
         rst_b = 1'b1; vld_b = 1'b0; clr_b = 1'b0;
      end
      e.sel  = sel;
      e.expv = {lk, er, st, 16'(cnt)};
      e.name = name;
      q.push_back(e);
      @(posedge clk);
      #3;
   endtask

   initial begin
      rst_a = 1'b0; vld_a = 1'b0; dat_a = '0; clr_a = 1'b0;
      rst_b = 1'b0; vld_b = 1'b0; dat_b = '0; clr_b = 1'b0;
      repeat (2) @(posedge clk);
      #3;

      // 1: reset with random traffic, then release with no valid samples
      for (int i = 0; i < 3; i++)
         step(0, 0, 1'($urandom_range(1)), 4'($urandom), 1'($urandom_range(1)), 0, 0, 0, 0, "reset_hold");
      step(0, 1, 0, 4'hF, 0, 0, 0, 0, 0, "idle_after_reset0");
      step(0, 1, 0, 4'h0, 0, 0, 0, 0, 0, "idle_after_reset1");

      // 2: lock onto the default sequence
      step(0, 1, 1, 4'b0001, 0, 0, 0, 0, 0, "hunt_0001");
      step(0, 1, 1, 4'b0010, 0, 0, 0, 0, 0, "hunt_0010");
      step(0, 1, 1, 4'b0100, 0, 0, 0, 0, 0, "hunt_0100");
      step(0, 1, 1, 4'b1001, 0, 0, 0, 0, 0, "hunt_1001");
      step(0, 1, 1, 4'b0011, 0, 1, 0, 0, 0, "lock_0011");

      // 3: single zero sample in place of 0110, stuck holds across an idle cycle
      step(0, 1, 1, 4'b0000, 0, 1, 1, 1, 1, "zero_mismatch");
      step(0, 1, 0, 4'b1111, 0, 1, 0, 1, 1, "idle_holds_stuck");
      step(0, 1, 1, 4'b1101, 0, 1, 0, 1, 0, "resume_1101");

      // 4: clear, then three misses drop lock; relock from 1111 after four good transitions
      step(0, 1, 0, 4'b0000, 1, 1, 0, 0, 0, "clear_idle");
      step(0, 1, 1, 4'b1111, 0, 1, 1, 1, 0, "miss1");
      step(0, 1, 1, 4'b1111, 0, 1, 1, 2, 0, "miss2");
      step(0, 1, 1, 4'b1111, 0, 0, 1, 3, 0, "miss3_unlock");
      step(0, 1, 1, 4'b1110, 0, 0, 0, 3, 0, "rehunt_1110");
      step(0, 1, 1, 4'b1100, 0, 0, 0, 3, 0, "rehunt_1100");
      step(0, 1, 1, 4'b1000, 0, 0, 0, 3, 0, "rehunt_1000");
      step(0, 1, 1, 4'b0001, 0, 1, 0, 3, 0, "relock_0001");

      // 5: gapped valid, same lock point in samples; clear with concurrent mismatch
      step(0, 0, 1, 4'b0101, 0, 0, 0, 0, 0, "reset_before_gapped");
      step(0, 1, 1, 4'b0001, 0, 0, 0, 0, 0, "gap_0001");
      step(0, 1, 0, 4'b1111, 0, 0, 0, 0, 0, "gap_idle0");
      step(0, 1, 1, 4'b0010, 0, 0, 0, 0, 0, "gap_0010");
      step(0, 1, 0, 4'b0000, 0, 0, 0, 0, 0, "gap_idle1");
      step(0, 1, 1, 4'b0100, 0, 0, 0, 0, 0, "gap_0100");
      step(0, 1, 0, 4'b1010, 0, 0, 0, 0, 0, "gap_idle2");
      step(0, 1, 1, 4'b1001, 0, 0, 0, 0, 0, "gap_1001");
      step(0, 1, 0, 4'b0111, 0, 0, 0, 0, 0, "gap_idle3");
      step(0, 1, 1, 4'b0011, 0, 1, 0, 0, 0, "gap_lock_0011");
      step(0, 1, 0, 4'b0000, 0, 1, 0, 0, 0, "gap_idle_locked");
      step(0, 1, 1, 4'b1111, 1, 1, 1, 1, 0, "clear_with_miss");
      step(0, 1, 1, 4'b1101, 0, 1, 0, 1, 0, "good_after_clear");
      step(0, 1, 1, 4'b1010, 1, 1, 0, 0, 0, "clear_no_miss");

      // 6: two-bit counter saturates; reset while locked
      step(1, 1, 1, 4'b0001, 0, 0, 0, 0, 0, "b_hunt_0001");
      step(1, 1, 1, 4'b0010, 0, 0, 0, 0, 0, "b_hunt_0010");
      step(1, 1, 1, 4'b0100, 0, 0, 0, 0, 0, "b_hunt_0100");
      step(1, 1, 1, 4'b1001, 0, 0, 0, 0, 0, "b_hunt_1001");
      step(1, 1, 1, 4'b0011, 0, 1, 0, 0, 0, "b_lock_0011");
      step(1, 1, 1, 4'b1111, 0, 1, 1, 1, 0, "b_miss_a");
      step(1, 1, 1, 4'b1101, 0, 1, 0, 1, 0, "b_good_1101");
      step(1, 1, 1, 4'b0000, 0, 1, 1, 2, 1, "b_miss_b");
      step(1, 1, 1, 4'b0101, 0, 1, 0, 2, 0, "b_good_0101");
      step(1, 1, 1, 4'b1111, 0, 1, 1, 3, 0, "b_miss_c");
      step(1, 1, 1, 4'b0111, 0, 1, 0, 3, 0, "b_good_0111");
      step(1, 1, 1, 4'b0000, 0, 1, 1, 3, 1, "b_miss_d_sat");
      step(1, 1, 1, 4'b1110, 0, 1, 0, 3, 0, "b_good_1110");
      step(1, 1, 1, 4'b1111, 0, 1, 1, 3, 0, "b_miss_e_sat");
      step(1, 1, 1, 4'b1000, 0, 1, 0, 3, 0, "b_good_1000");
      step(1, 0, 1, 4'b0001, 0, 0, 0, 0, 0, "b_reset_locked");
      step(1, 1, 0, 4'b0010, 0, 0, 0, 0, 0, "b_after_reset");

      // wait for the monitor to drain, bounded
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      if (q.size() > 0) begin
         tests_failed++;
         $display("FAIL drain: %0d checks pending, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
